// File: rtl/sadd8_rr_arbiter.sv
// Round-robin front end for one shared registered signed adder (s = a+b, overflow flag).
// Latency 1 cycle from transfer to rsp_valid; throughput 1 result per cycle.
// Backpressure: rsp_valid && !rsp_ready holds rsp_* and drops every req_ready.
//
// Ports:
//   clk, areset_n                  clock, asynchronous active-low reset
//   req_valid/req_a/req_b          per-requester operands (requester i at [i*WIDTH +: WIDTH])
//   req_ready                      one-hot (or zero) grant, transfer = valid & ready
//   rsp_valid/rsp_ready            single response slot handshake
//   rsp_id/rsp_s/rsp_overflow      requester index, sum and signed overflow of held result
//   ovf_sticky/ovf_clear           per-requester sticky overflow, synchronous clear
// Build option: define SADD_SATURATE_EN to clamp rsp_s on overflow instead of wrapping.
module sadd8_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [WIDTH-1:0]         rsp_s,
  output logic                     rsp_overflow,
  output logic [NREQ-1:0]          ovf_sticky,
  input  logic                     ovf_clear
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0]   ptr;        // last granted requester
  logic [IDW-1:0]   gid;
  logic [NREQ-1:0]  grant;
  logic             found;
  logic             slot_free;
  logic             xfer;
  logic             nxt_valid;
  logic [WIDTH-1:0] a_sel, b_sel, sum, s_res;
  logic             ovf;

  assign slot_free = !rsp_valid || rsp_ready;

  // Rotating priority search starting one past the last grant.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    gid   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gid        = idx[IDW-1:0];
        found      = 1'b1;
      end
    end
  end

  // Reset is folded in so no grant is advertised while areset_n is low.
  assign xfer = found && slot_free && areset_n;

  assign a_sel = req_a[int'(gid)*WIDTH +: WIDTH];
  assign b_sel = req_b[int'(gid)*WIDTH +: WIDTH];
  assign sum   = a_sel + b_sel;
  assign ovf   = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum[WIDTH-1] != a_sel[WIDTH-1]);

`ifdef SADD_SATURATE_EN
  // Overflow direction follows the common operand sign.
  always_comb begin
    s_res = sum;
    if (ovf)
      s_res = a_sel[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign s_res = sum;
`endif

  // FSM state register: EMPTY/FULL is rsp_valid itself.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) rsp_valid <= 1'b0;
    else           rsp_valid <= nxt_valid;
  end

  // FSM next state.
  always_comb begin
    nxt_valid = rsp_valid;
    case (rsp_valid)
      1'b0:    nxt_valid = xfer;
      default: nxt_valid = xfer || !rsp_ready;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready = '0;
    if (xfer) req_ready = grant;
  end

  // Response payload and round-robin pointer.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      rsp_id       <= '0;
      rsp_s        <= '0;
      rsp_overflow <= 1'b0;
      ptr          <= IDW'(NREQ-1);
    end else if (xfer) begin
      rsp_id       <= gid;
      rsp_s        <= s_res;
      rsp_overflow <= ovf;
      ptr          <= gid;
    end
  end

  // Sticky overflow: a set on the same edge as a clear survives.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n)
      ovf_sticky <= '0;
    else
      ovf_sticky <= (ovf_clear ? '0 : ovf_sticky) | ((xfer && ovf) ? grant : '0);
  end

endmodule
